dmux_merge4: RTL and testbench

- Inverse of the DMUXS 1-to-4 splitter: merges four N-bit lanes back into one output stream.
- Tags each output word with the 2-bit select code of its source lane, so a downstream DMUXS can re-split the stream unchanged.
- Sits where lane-parallel FPTD processing reconverges.
- Round-robin arbitration, one-entry registered output, valid/ready handshake on every port.

---
 rtl/dmux_merge4.sv | 128 ++++++++++++
 tb/tb_dmux_merge4.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_merge4.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// dmux_merge4 : round-robin 4-to-1 lane merger that tags each word with its source select code
// Revision    : 1.0
// ---------------------------------------------------------------------------
module dmux_merge4 #(
  parameter int N  = 98,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  INA,
  input  logic [N-1:0]  INB,
  input  logic [N-1:0]  INC,
  input  logic [N-1:0]  IND,
  input  logic          VALIDA,
  input  logic          VALIDB,
  input  logic          VALIDC,
  input  logic          VALIDD,
  output logic          READYA,
  output logic          READYB,
  output logic          READYC,
  output logic          READYD,
  output logic [N-1:0]  OUT,
  output logic          S1,
  output logic          S2,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [CW-1:0] CNT
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t       state;
  logic [1:0]   last;
  logic [3:0]   valid_vec;
  logic [3:0]   ready_vec;
  logic         load;
  logic         grant_valid;
  logic [1:0]   grant;
  logic [1:0]   idx;
  logic [N-1:0] sel_data;
  logic         xfer;

  assign valid_vec = {VALIDD, VALIDC, VALIDB, VALIDA};
  assign load      = (state == ST_EMPTY) || OUT_READY;

  // Search starts just after the last granted lane, so the most recent winner has lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    idx         = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!grant_valid && valid_vec[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    ready_vec = 4'b0000;
    if (!RST && load && grant_valid) begin
      ready_vec[grant] = 1'b1;
    end
  end

  assign READYA = ready_vec[0];
  assign READYB = ready_vec[1];
  assign READYC = ready_vec[2];
  assign READYD = ready_vec[3];

  assign xfer = |(ready_vec & valid_vec);

  always_comb begin
    sel_data = INA;
    case (grant)
      2'd0:    sel_data = INA;
      2'd1:    sel_data = INB;
      2'd2:    sel_data = INC;
      default: sel_data = IND;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_EMPTY;
      OUT       <= '0;
      S1        <= 1'b0;
      S2        <= 1'b0;
      OUT_VALID <= 1'b0;
      CNT       <= '0;
      last      <= 2'd3;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer) begin
            state <= ST_FULL;
          end
        end
        default: begin
          if (!xfer && OUT_READY) begin
            state <= ST_EMPTY;
          end
        end
      endcase

      if (xfer) begin
        OUT       <= sel_data;
        S1        <= grant[0];
        S2        <= grant[1];
        OUT_VALID <= 1'b1;
        last      <= grant;
        CNT       <= CNT + CW'(1);
      end else if (OUT_VALID && OUT_READY) begin
        // Drain keeps the last data/tag visible; only the valid flag drops.
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmux_merge4.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmux_merge4 : directed self-checking bench for dmux_merge4
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_dmux_merge4;

  localparam int N  = 98;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ina, inb, inc, ind;
  logic          valida, validb, validc, validd;
  logic          readya, readyb, readyc, readyd;
  logic [N-1:0]  out_data;
  logic          s1, s2;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  dmux_merge4 #(.N(N), .CW(CW)) dut (
    .CLK(clk), .RST(rst),
    .INA(ina), .INB(inb), .INC(inc), .IND(ind),
    .VALIDA(valida), .VALIDB(validb), .VALIDC(validc), .VALIDD(validd),
    .READYA(readya), .READYB(readyb), .READYC(readyc), .READYD(readyd),
    .OUT(out_data), .S1(s1), .S2(s2),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .CNT(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] readys();
    return {readyd, readyc, readyb, readya};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [3:0] v);
    {validd, validc, validb, valida} = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_valid(4'b0000);
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_valid(4'b1111);
    out_ready = 1'b1;
    #1;
    checks++;
    if (readys() !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", readys());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || cnt !== '0 || {s2, s1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got valid=%b out=%0d cnt=%0d s=%b expected 0 0 0 00",
               out_valid, out_data, cnt, {s2, s1});
    end
    rst = 1'b0;
    set_valid(4'b0000);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_data [4];
    do_reset();
    ina = 4532; inb = 4533; inc = 4534; ind = 4535;
    exp_data[0] = 4532; exp_data[1] = 4533; exp_data[2] = 4534; exp_data[3] = 4535;
    set_valid(4'b1111);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (readys() !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, readys(), 4'(1 << (i % 4)));
      end
      tick();
      checks++;
      if (out_data !== exp_data[i % 4] || {s2, s1} !== 2'(i % 4) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_out[%0d]: got out=%0d s=%b v=%b expected out=%0d s=%b v=1",
                 i, out_data, {s2, s1}, out_valid, exp_data[i % 4], 2'(i % 4));
      end
      if (i == 3) begin
        checks++;
        if (cnt !== 16'd4) begin
          errors++; $display("FAIL rr_cnt: got %0d expected 4", cnt);
        end
      end
    end
  endtask

  task automatic test_single_lane();
    int bad = 0;
    do_reset();
    inc = 4532;
    set_valid(4'b0100);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (readys() !== 4'b0100) bad++;
      tick();
      if (out_data !== 4532 || {s2, s1} !== 2'b10 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL single_lane_stream: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (cnt !== 16'd10) begin
      errors++; $display("FAIL single_lane_cnt: got %0d expected 10", cnt);
    end
  endtask

  task automatic test_drain();
    set_valid(4'b0000);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4532 || {s2, s1} !== 2'b10 || cnt !== 16'd10) begin
      errors++;
      $display("FAIL drain: got v=%b out=%0d s=%b cnt=%0d expected v=0 out=4532 s=10 cnt=10",
               out_valid, out_data, {s2, s1}, cnt);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    do_reset();
    inb = 4532;
    set_valid(4'b0010);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 4532 || {s2, s1} !== 2'b01 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_load: got out=%0d s=%b v=%b expected 4532 01 1",
                         out_data, {s2, s1}, out_valid);
    end
    ina = 1111; inb = 2222; inc = 3333; ind = 4444;
    set_valid(4'b1111);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (readys() !== 4'b0000) bad++;
      tick();
      if (out_data !== 4532 || {s2, s1} !== 2'b01 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (readys() !== 4'b0100) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 0100", readys());
    end
    tick();
    checks++;
    if (out_data !== 3333 || {s2, s1} !== 2'b10) begin
      errors++; $display("FAIL stall_release_out: got out=%0d s=%b expected 3333 10", out_data, {s2, s1});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (readys() !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_ready: got %b expected 0000", readys());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || cnt !== '0) begin
      errors++; $display("FAIL mid_reset_state: got v=%b out=%0d cnt=%0d expected 0 0 0",
                         out_valid, out_data, cnt);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 1111 || {s2, s1} !== 2'b00 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset_first: got out=%0d s=%b v=%b expected 1111 00 1",
                         out_data, {s2, s1}, out_valid);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    ina = 4532;
    set_valid(4'b0001);
    out_ready = 1'b1;
    repeat (65535) tick();
    checks++;
    if (cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_preset: got %0d expected 65535", cnt);
    end
    tick();
    checks++;
    if (cnt !== 16'd0 || out_data !== 4532 || {s2, s1} !== 2'b00 || out_valid !== 1'b1) begin
      errors++; $display("FAIL cnt_wrap: got cnt=%0d out=%0d s=%b v=%b expected 0 4532 00 1",
                         cnt, out_data, {s2, s1}, out_valid);
    end
  endtask

  // Upstream splitter model: the select code routes one word of 4532 to exactly one lane.
  task automatic test_loopback();
    logic [1:0] code;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = 2'(i);
      ina = 4532; inb = 4532; inc = 4532; ind = 4532;
      set_valid(4'(1 << code));
      tick();
      checks++;
      if (out_data !== 4532 || {s2, s1} !== code || out_valid !== 1'b1) begin
        errors++; $display("FAIL loopback[%0d]: got out=%0d s=%b expected 4532 %b",
                           i, out_data, {s2, s1}, code);
      end
    end
    set_valid(4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    ina = '0; inb = '0; inc = '0; ind = '0;
    set_valid(4'b0000);
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_single_lane();
    test_drain();
    test_stall();
    test_reset_mid();
    test_cnt_wrap();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
